// File: rtl/dp_controller_if.sv
// dp_controller_if: instruction handshake, datapath status and datapath control bundle
//   master: instruction source (drives instr, instr_valid, status_in)
//   slave : dp_controller (drives instr_ready, done, illegal and every datapath control)
interface dp_controller_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] status_in;
  logic        done;
  logic        illegal;
  logic [3:0]  w_addr;
  logic [3:0]  A_addr;
  logic [3:0]  B_addr;
  logic [3:0]  shift_addr;
  logic        w_en;
  logic        en_A;
  logic        en_B;
  logic        en_S;
  logic        en_status;
  logic        sel_shift;
  logic        sel_A;
  logic        sel_B;
  logic [1:0]  shift_op;
  logic [31:0] shift_imme;
  logic [31:0] imme_data;
  logic [2:0]  ALU_op;
  modport master (
    output instr, instr_valid, status_in,
    input  instr_ready, done, illegal, w_addr, A_addr, B_addr, shift_addr,
           w_en, en_A, en_B, en_S, en_status, sel_shift, sel_A, sel_B,
           shift_op, shift_imme, imme_data, ALU_op
  );
  modport slave (
    input  instr, instr_valid, status_in,
    output instr_ready, done, illegal, w_addr, A_addr, B_addr, shift_addr,
           w_en, en_A, en_B, en_S, en_status, sel_shift, sel_A, sel_B,
           shift_op, shift_imme, imme_data, ALU_op
  );
endinterface

// File: rtl/dp_controller.sv
// dp_controller: IDLE->DECODE->LOAD->EXEC sequencer driving the ARM32 datapath controls
//   clk   : rising-edge clock shared with the datapath
//   rst_n : asynchronous active-low reset
//   bus   : dp_controller_if.slave (instruction handshake, status_in, done/illegal, controls)
module dp_controller (
  input logic          clk,
  input logic          rst_n,
  dp_controller_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] LOAD   = 2'd2;
  localparam logic [1:0] EXEC   = 2'd3;
  logic [1:0]  state;
  logic [31:0] ir;
  logic        done_q, illegal_q;
  logic [3:0]  cond, opc;
  logic        imm, s_bit, is_cmp, is_mov, op_ok, cond_ok, bad, pass;
  logic        n, z, v, ld, ex, le, op2;
  logic [2:0]  alu;
  logic [31:0] imm8, rot;
  logic [4:0]  rot_amt;
  assign cond    = ir[31:28];
  assign opc     = ir[24:21];
  assign imm     = ir[25];
  assign s_bit   = ir[20];
  assign is_cmp  = opc == 4'b1010;
  assign is_mov  = opc == 4'b1101;
  assign op_ok   = opc inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1010, 4'b1100, 4'b1101};
  assign cond_ok = cond inside {4'b0000, 4'b0001, 4'b1010, 4'b1011, 4'b1110};
  assign bad     = !op_ok || !cond_ok || ir[27:26] != 2'b00 || (!imm && ir[4] && ir[7]);
  assign n       = bus.status_in[31];
  assign z       = bus.status_in[30];
  assign v       = bus.status_in[28];
  assign pass    = cond == 4'b0000 ? z :
                   cond == 4'b0001 ? !z :
                   cond == 4'b1010 ? n == v :
                   cond == 4'b1011 ? n != v : 1'b1;
  assign alu     = opc == 4'b0000 ? 3'b010 :
                   opc == 4'b0001 ? 3'b100 :
                   opc == 4'b0010 ? 3'b001 :
                   opc == 4'b1010 ? 3'b001 :
                   opc == 4'b1100 ? 3'b011 : 3'b000;
  // rotate-right of the 8-bit immediate; a zero amount shifts the left term fully out
  assign imm8    = {24'b0, ir[7:0]};
  assign rot_amt = {ir[11:8], 1'b0};
  assign rot     = (imm8 >> rot_amt) | (imm8 << (6'd32 - {1'b0, rot_amt}));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      ir        <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state)
        IDLE:   if (bus.instr_valid) begin
                  ir    <= bus.instr;
                  state <= DECODE;
                end
        DECODE: if (bad || !pass) begin
                  state     <= IDLE;
                  done_q    <= 1'b1;
                  illegal_q <= bad;
                end else
                  state <= LOAD;
        LOAD:   state <= EXEC;
        EXEC:   begin
                  state  <= IDLE;
                  done_q <= 1'b1;
                end
      endcase
    end
  // operand fetch controls are held from LOAD through EXEC; register operand 2 only when I=0
  assign ld  = state == LOAD;
  assign ex  = state == EXEC;
  assign le  = ld || ex;
  assign op2 = le && !imm;
  assign bus.instr_ready = state == IDLE;
  assign bus.done        = done_q;
  assign bus.illegal     = illegal_q;
  assign bus.A_addr      = le  ? ir[19:16] : 4'd0;
  assign bus.B_addr      = op2 ? ir[3:0]   : 4'd0;
  assign bus.shift_addr  = op2 ? ir[11:8]  : 4'd0;
  assign bus.shift_op    = op2 ? ir[6:5]   : 2'd0;
  assign bus.shift_imme  = op2 ? {27'b0, ir[11:7]} : 32'd0;
  assign bus.sel_shift   = op2 && ir[4];
  assign bus.en_A        = ld;
  assign bus.en_B        = ld;
  assign bus.en_S        = ld;
  assign bus.ALU_op      = ex ? alu : 3'd0;
  assign bus.sel_A       = ex && is_mov;
  assign bus.sel_B       = ex && imm;
  assign bus.imme_data   = ex && imm ? rot : 32'd0;
  assign bus.w_addr      = ex ? ir[15:12] : 4'd0;
  assign bus.w_en        = ex && !is_cmp;
  assign bus.en_status   = ex && (s_bit || is_cmp);
endmodule

// File: tb/tb_dp_controller.sv
// tb_dp_controller: table-driven and scoreboard-checked bench for dp_controller
module tb_dp_controller;
  typedef struct {
    logic [31:0] ins;
    logic [31:0] st;
    int          kind;
    bit          op2;
    logic [3:0]  a, b, sa;
    logic [1:0]  sop;
    logic [31:0] simm;
    logic        ssel;
    logic [2:0]  alu;
    logic        sela, selb;
    logic [31:0] imm;
    logic [3:0]  wa;
    logic        wen, enst;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_mis = 0;
  vec_t tbl[16];
  vec_t sbq[$];
  dp_controller_if bus ();
  dp_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] ctl();
    return {3'b0, bus.w_addr, bus.A_addr, bus.B_addr, bus.shift_addr, bus.w_en, bus.en_A,
            bus.en_B, bus.en_S, bus.en_status, bus.sel_shift, bus.sel_A, bus.sel_B,
            bus.shift_op, bus.ALU_op};
  endfunction
  task automatic chk_idle(input string nm);
    chk({nm, "_ctl"}, ctl(), 0);
    chk({nm, "_imm"}, bus.shift_imme | bus.imme_data, 0);
  endtask
  task automatic chk_op2(input string nm, input vec_t v);
    chk({nm, "_B_addr"}, bus.B_addr, v.b);
    chk({nm, "_shift_addr"}, bus.shift_addr, v.sa);
    chk({nm, "_shift_op"}, bus.shift_op, v.sop);
    chk({nm, "_shift_imme"}, bus.shift_imme, v.simm);
    chk({nm, "_sel_shift"}, bus.sel_shift, v.ssel);
  endtask
  task automatic run_vec(input vec_t v);
    vec_t e;
    int w = 0;
    bit seen = 0;
    while (!bus.instr_ready && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
    chk("ready_before_accept", bus.instr_ready, 1);
    bus.instr = v.ins;
    bus.status_in = v.st;
    bus.instr_valid = 1'b1;
    sbq.push_back(v);
    @(posedge clk); #1;
    bus.instr = $urandom;
    chk("decode_ready", bus.instr_ready, 0);
    chk("decode_done", bus.done, 0);
    chk_idle("decode");
    @(negedge clk);
    bus.instr_valid = 1'b0;
    for (int c = 2; c <= 6 && !seen; c++) begin
      @(posedge clk); #1;
      if (c == 2) bus.status_in = ~v.st;
      if (bus.done) begin
        seen = 1;
        e = sbq.pop_front();
        chk("retire_cycle", c, e.kind == 0 ? 4 : 2);
        chk("illegal", bus.illegal, e.kind == 2);
        chk("retire_ready", bus.instr_ready, 1);
        chk_idle("retire");
      end else if (c == 2 && v.kind == 0) begin
        chk("load_A_addr", bus.A_addr, v.a);
        chk("load_enables", {bus.en_A, bus.en_B, bus.en_S}, 3'b111);
        chk("load_exec_ctl", {bus.w_addr, bus.w_en, bus.en_status, bus.sel_A, bus.sel_B, bus.ALU_op}, 0);
        chk("load_imme_data", bus.imme_data, 0);
        if (v.op2) chk_op2("load", v);
      end else if (c == 3 && v.kind == 0) begin
        chk("exec_enables", {bus.en_A, bus.en_B, bus.en_S}, 0);
        chk("exec_A_addr", bus.A_addr, v.a);
        if (v.op2) chk_op2("exec", v);
        chk("exec_ALU_op", bus.ALU_op, v.alu);
        chk("exec_sel_A", bus.sel_A, v.sela);
        chk("exec_sel_B", bus.sel_B, v.selb);
        chk("exec_imme_data", bus.imme_data, v.imm);
        chk("exec_w_addr", bus.w_addr, v.wa);
        chk("exec_w_en", bus.w_en, v.wen);
        chk("exec_en_status", bus.en_status, v.enst);
      end else
        chk_idle("wait");
    end
    if (!seen) begin
      n_vec++;
      n_mis++;
      $display("FAIL done_timeout: got no done want done within 6 cycles");
      void'(sbq.pop_front());
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end
  initial begin
    tbl[0]  = '{32'hE3A010FF, 32'h0, 0, 0, 4'd0, 4'd0, 4'd0, 2'd0, 32'd0, 1'b0, 3'b000, 1'b1, 1'b1, 32'h000000FF, 4'd1, 1'b1, 1'b0};
    tbl[1]  = '{32'hE0812203, 32'h0, 0, 1, 4'd1, 4'd3, 4'd2, 2'd0, 32'd4, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 4'd2, 1'b1, 1'b0};
    tbl[2]  = '{32'hE0514533, 32'h0, 0, 1, 4'd1, 4'd3, 4'd5, 2'd1, 32'd10, 1'b1, 3'b001, 1'b0, 1'b0, 32'h0, 4'd4, 1'b1, 1'b1};
    tbl[3]  = '{32'hE3A004FF, 32'h0, 0, 0, 4'd0, 4'd0, 4'd0, 2'd0, 32'd0, 1'b0, 3'b000, 1'b1, 1'b1, 32'hFF000000, 4'd0, 1'b1, 1'b0};
    tbl[4]  = '{32'hE1510003, 32'h0, 0, 1, 4'd1, 4'd3, 4'd0, 2'd0, 32'd0, 1'b0, 3'b001, 1'b0, 1'b0, 32'h0, 4'd0, 1'b0, 1'b1};
    tbl[5]  = '{32'h00812203, 32'h40000000, 0, 1, 4'd1, 4'd3, 4'd2, 2'd0, 32'd4, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 4'd2, 1'b1, 1'b0};
    tbl[6]  = '{32'h00812203, 32'h0, 1, 0, 4'd0, 4'd0, 4'd0, 2'd0, 32'd0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 4'd0, 1'b0, 1'b0};
    tbl[7]  = '{32'hE0010392, 32'h0, 2, 0, 4'd0, 4'd0, 4'd0, 2'd0, 32'd0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 4'd0, 1'b0, 1'b0};
    tbl[8]  = '{32'hF0812203, 32'h0, 2, 0, 4'd0, 4'd0, 4'd0, 2'd0, 32'd0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 4'd0, 1'b0, 1'b0};
    tbl[9]  = '{32'hB1812203, 32'h80000000, 0, 1, 4'd1, 4'd3, 4'd2, 2'd0, 32'd4, 1'b0, 3'b011, 1'b0, 1'b0, 32'h0, 4'd2, 1'b1, 1'b0};
    tbl[10] = '{32'hA0012203, 32'h80000000, 1, 0, 4'd0, 4'd0, 4'd0, 2'd0, 32'd0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 4'd0, 1'b0, 1'b0};
    tbl[11] = '{32'h10212203, 32'h0, 0, 1, 4'd1, 4'd3, 4'd2, 2'd0, 32'd4, 1'b0, 3'b100, 1'b0, 1'b0, 32'h0, 4'd2, 1'b1, 1'b0};
    tbl[12] = '{32'hE4812203, 32'h0, 2, 0, 4'd0, 4'd0, 4'd0, 2'd0, 32'd0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 4'd0, 1'b0, 1'b0};
    tbl[13] = '{32'hE0612203, 32'h0, 2, 0, 4'd0, 4'd0, 4'd0, 2'd0, 32'd0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 4'd0, 1'b0, 1'b0};
    tbl[14] = '{32'hA0812203, 32'h90000000, 0, 1, 4'd1, 4'd3, 4'd2, 2'd0, 32'd4, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 4'd2, 1'b1, 1'b0};
    tbl[15] = '{32'hE3A01F90, 32'h0, 0, 0, 4'd0, 4'd0, 4'd0, 2'd0, 32'd0, 1'b0, 3'b000, 1'b1, 1'b1, 32'h00000240, 4'd1, 1'b1, 1'b0};
    bus.instr = '0;
    bus.instr_valid = 1'b0;
    bus.status_in = '0;
    #12;
    chk("reset_ready", bus.instr_ready, 1);
    chk("reset_done", {bus.done, bus.illegal}, 0);
    chk_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) run_vec(tbl[i]);
    bus.instr = 32'hE0812203;
    bus.status_in = '0;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_pre_w_en", bus.w_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_ctl", ctl(), 0);
    chk("rst_async_w_en", bus.w_en, 0);
    chk("rst_async_ready", bus.instr_ready, 1);
    chk("rst_async_done", bus.done, 0);
    @(posedge clk); #1;
    chk("rst_hold_done", bus.done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_after_done", bus.done, 0);
    chk("rst_after_ready", bus.instr_ready, 1);
    chk_idle("rst_after");
    run_vec(tbl[1]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/dp_controller.md
# dp_controller

Multicycle control sequencer that sits directly upstream of the ARM32 datapath. It accepts one 32-bit ARM data-processing instruction per handshake and decodes it. It then drives every datapath control input over a fixed LOAD→EXEC sequence and reports completion. Condition evaluation uses the datapath's registered status word.

## Interface
- Parameters: none (instruction width 32, register index width 4 fixed).
- clk  in  1  rising-edge clock shared with the datapath
- rst_n  in  1  asynchronous, active-low reset
- instr  in  32  instruction word; sampled on the accept edge
- instr_valid  in  1  instruction offered
- instr_ready  out  1  controller can accept; high only in IDLE
- status_in  in  32  datapath status_out; [31]=N, [30]=Z, [29]=C, [28]=V
- done  out  1  one-cycle pulse: instruction retired (executed, skipped or illegal)
- illegal  out  1  one-cycle pulse coincident with done for an unsupported encoding
- w_addr, A_addr, B_addr, shift_addr  out  4 each  register indices
- w_en, en_A, en_B, en_S, en_status, sel_shift, sel_A, sel_B  out  1 each  datapath controls
- shift_op  out  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
- shift_imme  out  32  zero-extended instr[11:7]
- imme_data  out  32  rotated immediate
- ALU_op  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR

## Operation
- Instruction fields: cond=[31:28], I=[25], opcode=[24:21], S=[20], Rn=[19:16], Rd=[15:12].
- Operand 2 when I=0: Rm=[3:0], shift type=[6:5]. Bit4=0 gives an immediate amount [11:7]. Bit4=1 takes the amount from Rs=[11:8]; bit7 must be 0.
- Supported opcodes:
  - AND 0000 → op 010
  - EOR 0001 → op 100
  - SUB 0010 → op 001
  - ADD 0100 → op 000
  - CMP 1010 → op 001, no writeback, en_status forced
  - ORR 1100 → op 011
  - MOV 1101 → op 000 with sel_A=1
- Supported cond values:
  - EQ 0000: pass when Z
  - NE 0001: pass when !Z
  - GE 1010: pass when N==V
  - LT 1011: pass when N!=V
  - AL 1110: always pass
- Illegal encodings; each retires with illegal=1 and no datapath writes:
  - any other opcode
  - any other cond
  - [27:26]≠00
  - I=0 with bit4=1 and bit7=1
- Immediate operand (I=1): imme_data = {24'b0, instr[7:0]} rotated right by 2×instr[11:8], with sel_B=1. When I=0, sel_B=0 and imme_data=0.
- An immediate shift amount of 0 means no shift for all types; there is no LSR/ASR #32 or RRX special case.
- FSM states: IDLE, DECODE, LOAD, EXEC.
  - IDLE: instr_ready=1. instr_valid=1 latches instr, then go to DECODE.
  - DECODE: evaluate illegality and cond against status_in.
    - Illegal or cond fail: return to IDLE with done pulse; illegal pulse if illegal.
    - Otherwise go to LOAD.
  - LOAD: drive A_addr=Rn, B_addr=Rm, shift_addr=Rs, shift_op, shift_imme, sel_shift=bit4 (I=0 only). Assert en_A, en_B, en_S. Then go to EXEC.
  - EXEC: keep A_addr, B_addr, shift_addr, shift_op, shift_imme, sel_shift at their LOAD values. Drive ALU_op, sel_A, sel_B, imme_data. w_addr=Rd. w_en=1 unless CMP. en_status=S|CMP. Then go to IDLE with done pulse.
- All control outputs are 0 in IDLE and DECODE. done and illegal are registered.

## Timing
- Accept edge = edge 0. DECODE occupies cycle 1, LOAD cycle 2 and EXEC cycle 3. The datapath register write and status write occur at edge 3.
- Executed instruction: done=1 during cycle 4, with instr_ready=1 in the same cycle, so back-to-back throughput is one instruction per 4 cycles.
- Skipped or illegal instruction: done=1 during cycle 2.
- Condition reads the status_in value present during DECODE. A preceding flag-setting instruction has already committed by then.
- instr_valid is ignored outside IDLE. instr may change after the accept edge.
- Reset: asynchronous assertion forces IDLE, clears the latched instr and drives every output to 0 except instr_ready. instr_ready=1 while rst_n=0. A reset in LOAD or EXEC aborts the instruction with no done pulse; a write already committed at an earlier edge stands.

## Test plan
- Reset mid-EXEC of ADD: rst_n low → outputs 0 immediately, w_en=0, no done; after release instr_ready=1.
- MOV R1,#0xFF (0xE3A010FF) → EXEC: sel_A=1, sel_B=1, imme_data=0xFF, ALU_op=000, w_addr=1, w_en=1; done at cycle 4.
- ADD R2,R1,R3,LSL #4 (0xE0812203) → LOAD: A_addr=1, B_addr=3, shift_imme=4, sel_shift=0, en_A/en_B/en_S=1. EXEC: w_addr=2.
- Register-shift and rotation:
  - SUBS R4,R1,R3,LSR R5 (0xE0514533) → sel_shift=1, shift_addr=5, shift_op=01, en_status=1.
  - 0xE3A004FF → imme_data=0xFF000000.
- CMP then BEQ-style ADDEQ:
  - With status_in[30]=1, ADDEQ executes.
  - With status_in[30]=0, it is skipped: done at cycle 2, no w_en.
  - CMP itself yields w_en=0, en_status=1.
- Opcode MUL-space 0xE0010392 and cond 0xF → illegal=1 with done at cycle 2, no enables asserted at any point.
